mac_sequencer: RTL

Sequences the signed 8x8→16 multiply-accumulate datapath through one dot product. Used for a convolution-kernel window (e.g. 9 taps for 3x3) or a fully-connected neuron. Accepts a command (length, bias, ReLU enable), consumes an activation/weight operand stream one pair per handshake, and accumulates through the MAC unit it instantiates. It then presents the 16-bit result on a valid/ready output port. Sits between the line-buffer/weight-ROM readers and the layer output writer.

---
 rtl/mac_sequencer.sv | 117 +++++++++++
 1 files changed

// File: rtl/mac_sequencer.sv
// Dot-product sequencer: one command, N operand pairs through a signed 8x8+16 MAC, one 16-bit result.
// Result is valid 1 cycle after the last operand handshake; it waits for op_valid bubbles and holds for res_ready.
module mac_unit (
  input  logic signed [7:0]  a,
  input  logic signed [7:0]  b,
  input  logic signed [15:0] accum_in,
  output logic signed [15:0] accum_out
);
  logic signed [15:0] prod;

  // Both operands are signed, so they sign-extend to the 16-bit product width.
  assign prod      = a * b;
  assign accum_out = accum_in + prod;
endmodule

module mac_sequencer #(
  parameter int LEN_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [LEN_W-1:0]        cmd_len,
  input  logic signed [15:0]      cmd_bias,
  input  logic                    cmd_relu,
  input  logic                    op_valid,
  output logic                    op_ready,
  input  logic signed [7:0]       op_a,
  input  logic signed [7:0]       op_b,
  input  logic                    op_last,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [15:0]      res_data,
  output logic                    res_len_err,
  output logic                    busy
);
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);
  localparam logic [LEN_W-1:0] LEN_ZERO = '0;

  state_e             state_q, state_d;
  logic signed [15:0] acc_q, acc_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               err_q, err_d;
  logic               relu_q, relu_d;
  logic signed [15:0] mac_out;
  logic               last_pair;

  mac_unit u_mac (
    .a         (op_a),
    .b         (op_b),
    .accum_in  (acc_q),
    .accum_out (mac_out)
  );

  assign last_pair = (rem_q == LEN_ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      err_q   <= 1'b0;
      relu_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      err_q   <= err_d;
      relu_q  <= relu_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    err_d   = err_q;
    relu_d  = relu_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          acc_d   = cmd_bias;
          relu_d  = cmd_relu;
          err_d   = 1'b0;
          rem_d   = cmd_len;
          state_d = (cmd_len == LEN_ZERO) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (op_valid) begin
          acc_d = mac_out;
          rem_d = rem_q - LEN_ONE;
          // op_last is only audited against the commanded length, never trusted for control.
          err_d = err_q | (op_last != last_pair);
          if (last_pair) state_d = DONE;
        end
      end
      DONE: begin
        if (res_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign cmd_ready   = (state_q == IDLE);
  assign op_ready    = (state_q == ACCUM);
  assign res_valid   = (state_q == DONE);
  assign busy        = (state_q != IDLE);
  assign res_data    = (relu_q && acc_q[15]) ? 16'sd0 : acc_q;
  assign res_len_err = err_q;
endmodule
